fpalu_issue_sched: RTL and testbench
====================================

# fpalu_issue_sched

Two-requester issue scheduler for the shared 4-stage FP ALU pipeline. It arbitrates between two operand sources with a round-robin policy and registers the granted operation into the ALU input bus. It tracks each in-flight operation's owner through a valid/ID shift chain that matches the ALU latency, and flags the returning result to the correct requester. Per-requester outstanding-credit counters bound how much of the pipeline each requester may occupy.

## Interface
Parameters:
- ALU_LAT, 4: ALU register stages from its inputs to its outputs; the ID chain length follows this value.
- MAX_OUT, 5: maximum operations in flight per requester, valid range 1..ALU_LAT+1.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_opcode  in  2  operation code
- req0_opnd  in  58  {a_sgn, a_exp[5:0], a_man_dn[21:0], b_sgn, b_exp[5:0], b_man_dn[21:0]}
- req1_valid / req1_ready / req1_opcode / req1_opnd: identical to requester 0
- alu_opcode  out  2  registered opcode to the ALU
- alu_a_sgn, alu_a_exp[5:0], alu_a_man_dn[21:0], alu_b_sgn, alu_b_exp[5:0], alu_b_man_dn[21:0]  out  registered operands
- alu_y_sgn  in  1, alu_y_exp  in  6, alu_y_man_dn  in  22: ALU result
- rsp0_valid  out  1  result belongs to requester 0
- rsp1_valid  out  1  result belongs to requester 1
- rsp_y  out  29  {alu_y_sgn, alu_y_exp, alu_y_man_dn}, passed through combinationally

## Operation
- Eligibility: requester k is eligible when `reqk_valid` is high and `cnt_k < MAX_OUT`.
- Grant: at most one grant per cycle, computed combinationally. If only one requester is eligible, it is granted. If both are eligible, the requester named by the priority pointer `ptr` is granted.
- `reqk_ready` equals `grant_k`. A transfer occurs when valid and ready are both high.
- Pointer update: on any grant, `ptr` becomes the requester that was not granted. With no grant, `ptr` holds.
- Issue register (stage 1): on a grant, it loads the opcode and operands onto the alu_* outputs and sets v1=1 with id1 set to the granted requester. With no grant, v1=0 and the alu_* outputs hold their previous values.
- ID chain: v/id shift from stage 1 through stage ALU_LAT+1 each cycle, with no stall. The chain is aligned so that stage ALU_LAT+1 coincides with the ALU result of that operation.
- Response: `rspk_valid = v[ALU_LAT+1] & (id[ALU_LAT+1]==k)`. There is no response backpressure; each requester must consume the result in that cycle.
- Credit counters `cnt_k` are ceil(log2(MAX_OUT+1)) bits wide and update at the clock edge:
  - Increment on an accept by k.
  - Decrement on `rspk_valid`.
  - Hold when both events occur in the same cycle.
  - Never wrap. Overflow or underflow is a design error and is asserted in simulation.

## Timing
- Reset values:
  - `ptr=0`, so requester 0 has first priority.
  - All v bits 0 and `cnt_0=cnt_1=0`.
  - `req0_ready=req1_ready=0` while rst is high.
  - `rsp0_valid=rsp1_valid=0`.
  - alu_* outputs are 0.
- Latency: an accept at cycle t produces alu_* valid at t+1 and `rspk_valid` plus `rsp_y` at t+1+ALU_LAT, which is t+5 with defaults.
- Throughput: one issue per cycle overall. With MAX_OUT=ALU_LAT+1, a single requester streams every cycle.
- With MAX_OUT=m<ALU_LAT+1, a lone requester issues m operations and then stalls until its first response cycle. The response frees the credit at the edge, so the next accept occurs in the cycle after `rsp_valid`.
- Simultaneous accept and response by the same requester leave `cnt` unchanged.
- Reset mid-operation clears every v bit and counter. Operations still draining through the ALU produce no `rsp_valid`, and `rsp_y` is don't-care.
- Responses are strictly in issue order because there is a single pipeline.

## Test plan
- Reset, then only req0_valid held high for 10 cycles, with defaults -> req0_ready high every cycle, and rsp0_valid high on cycles 5..14 after the first accept with matching operand-derived results in order. rsp1_valid stays 0.
- Both valid continuously from reset -> grants alternate 0,1,0,1,… with requester 0 first. The rsp0/rsp1 pulses alternate with a 5-cycle offset, and cnt_0 and cnt_1 each settle at 2 or 3.
- MAX_OUT=2, req0 only -> accepts at t and t+1, ready low from t+2 to t+5. rsp0_valid at t+5 and t+6, next accept at t+6.
- req1 alone for 1 cycle while ptr=0 -> req1 granted immediately and ptr becomes 0. Then both request -> req0 granted.
- rst asserted for 1 cycle with 3 operations in flight -> no rsp pulses follow. Counters read 0, and a new req0 accept returns rsp0_valid exactly 5 cycles later.
- Accept and response for req0 in the same cycle with cnt_0=3 -> cnt_0 remains 3.

Source files
------------

// File: rtl/fpalu_issue_sched.sv
// fpalu_issue_sched
//   Round-robin issue scheduler in front of the shared FP ALU pipeline.
//   Two requesters compete for one issue slot per cycle. The granted
//   operation is registered onto the alu_* bus, and its owner is carried
//   down a valid/ID chain that lines up with the ALU result. Per-requester
//   credit counters cap how many operations each side can have in flight.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqK_valid/ready             requester K handshake (ready == grant)
//   reqK_opcode[1:0]             requester K operation code
//   reqK_opnd[57:0]              {a_sgn, a_exp[5:0], a_man_dn[21:0],
//                                 b_sgn, b_exp[5:0], b_man_dn[21:0]}
//   alu_opcode, alu_a_*, alu_b_* registered operation to the ALU
//   alu_y_sgn/exp/man_dn         ALU result
//   rsp0_valid, rsp1_valid       result owner flags
//   rsp_y[28:0]                  {alu_y_sgn, alu_y_exp, alu_y_man_dn}
module fpalu_issue_sched #(
  parameter int ALU_LAT = 4,
  parameter int MAX_OUT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_opcode,
  input  logic [57:0] req0_opnd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_opcode,
  input  logic [57:0] req1_opnd,
  output logic [1:0]  alu_opcode,
  output logic        alu_a_sgn,
  output logic [5:0]  alu_a_exp,
  output logic [21:0] alu_a_man_dn,
  output logic        alu_b_sgn,
  output logic [5:0]  alu_b_exp,
  output logic [21:0] alu_b_man_dn,
  input  logic        alu_y_sgn,
  input  logic [5:0]  alu_y_exp,
  input  logic [21:0] alu_y_man_dn,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [28:0] rsp_y
);

  localparam int CW = $clog2(MAX_OUT + 1);
  // Chain stage 1 is the issue register; stage ALU_LAT+1 meets the result.
  localparam int NS = ALU_LAT + 1;

  logic          ptr_q, ptr_d;
  logic [NS-1:0] v_q, v_d;
  logic [NS-1:0] id_q, id_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic [1:0]    opc_q, opc_d;
  logic [57:0]   opnd_q, opnd_d;

  logic elig0, elig1;
  logic grant0, grant1;

  always_comb begin
    elig0 = req0_valid && (cnt0_q < CW'(MAX_OUT));
    elig1 = req1_valid && (cnt1_q < CW'(MAX_OUT));
    // ptr_q == 0 favours requester 0 on a tie. Reset forces ready low.
    grant0 = !rst && elig0 && (!elig1 || !ptr_q);
    grant1 = !rst && elig1 && (!elig0 || ptr_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign rsp0_valid = v_q[NS-1] & ~id_q[NS-1];
  assign rsp1_valid = v_q[NS-1] &  id_q[NS-1];
  assign rsp_y      = {alu_y_sgn, alu_y_exp, alu_y_man_dn};

  always_comb begin
    ptr_d  = ptr_q;
    opc_d  = opc_q;
    opnd_d = opnd_q;
    if (grant0) begin
      ptr_d  = 1'b1;
      opc_d  = req0_opcode;
      opnd_d = req0_opnd;
    end else if (grant1) begin
      ptr_d  = 1'b0;
      opc_d  = req1_opcode;
      opnd_d = req1_opnd;
    end

    // No stall anywhere in the ALU, so the chain shifts unconditionally.
    v_d  = {v_q[NS-2:0],  grant0 | grant1};
    id_d = {id_q[NS-2:0], grant1};

    case ({grant0, rsp0_valid})
      2'b10:   cnt0_d = cnt0_q + CW'(1);
      2'b01:   cnt0_d = cnt0_q - CW'(1);
      default: cnt0_d = cnt0_q;
    endcase
    case ({grant1, rsp1_valid})
      2'b10:   cnt1_d = cnt1_q + CW'(1);
      2'b01:   cnt1_d = cnt1_q - CW'(1);
      default: cnt1_d = cnt1_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= 1'b0;
      v_q    <= '0;
      id_q   <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
      opc_q  <= '0;
      opnd_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      v_q    <= v_d;
      id_q   <= id_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      opc_q  <= opc_d;
      opnd_q <= opnd_d;
    end
  end

  assign alu_opcode   = opc_q;
  assign alu_a_sgn    = opnd_q[57];
  assign alu_a_exp    = opnd_q[56:51];
  assign alu_a_man_dn = opnd_q[50:29];
  assign alu_b_sgn    = opnd_q[28];
  assign alu_b_exp    = opnd_q[27:22];
  assign alu_b_man_dn = opnd_q[21:0];

  // Credit counters must never wrap.
  a_cnt0_ovf: assert property (@(posedge clk) disable iff (rst)
    !(grant0 && !rsp0_valid && cnt0_q == CW'(MAX_OUT)));
  a_cnt1_ovf: assert property (@(posedge clk) disable iff (rst)
    !(grant1 && !rsp1_valid && cnt1_q == CW'(MAX_OUT)));
  a_cnt0_unf: assert property (@(posedge clk) disable iff (rst)
    !(rsp0_valid && !grant0 && cnt0_q == '0));
  a_cnt1_unf: assert property (@(posedge clk) disable iff (rst)
    !(rsp1_valid && !grant1 && cnt1_q == '0));

endmodule

// File: tb/tb_fpalu_issue_sched.sv
// Bench for fpalu_issue_sched. Instance u0 uses the default parameters,
// instance u1 uses MAX_OUT=2. A small ALU stand-in turns the registered
// alu_* bus into a result four cycles later. A reference model keeps a
// timeline of which requester is owed a response in which cycle and what
// the result must be, and is compared against both instances every cycle.
module tb_fpalu_issue_sched;

  logic clk;
  logic rst;

  logic        rv    [2][2];
  logic [1:0]  ropc  [2][2];
  logic [57:0] ropnd [2][2];
  logic        rrdy  [2][2];
  logic [1:0]  aopc  [2];
  logic        a_as  [2];
  logic [5:0]  a_ae  [2];
  logic [21:0] a_am  [2];
  logic        a_bs  [2];
  logic [5:0]  a_be  [2];
  logic [21:0] a_bm  [2];
  logic [28:0] ypipe [2][4];
  logic        rspv  [2][2];
  logic [28:0] rspy  [2];
  logic [2:0]  dcnt  [2][2];

  int n_tests = 0;
  int n_fail  = 0;
  int seq     = 0;

  fpalu_issue_sched u0 (
    .clk(clk), .rst(rst),
    .req0_valid(rv[0][0]), .req0_ready(rrdy[0][0]), .req0_opcode(ropc[0][0]), .req0_opnd(ropnd[0][0]),
    .req1_valid(rv[0][1]), .req1_ready(rrdy[0][1]), .req1_opcode(ropc[0][1]), .req1_opnd(ropnd[0][1]),
    .alu_opcode(aopc[0]), .alu_a_sgn(a_as[0]), .alu_a_exp(a_ae[0]), .alu_a_man_dn(a_am[0]),
    .alu_b_sgn(a_bs[0]), .alu_b_exp(a_be[0]), .alu_b_man_dn(a_bm[0]),
    .alu_y_sgn(ypipe[0][3][28]), .alu_y_exp(ypipe[0][3][27:22]), .alu_y_man_dn(ypipe[0][3][21:0]),
    .rsp0_valid(rspv[0][0]), .rsp1_valid(rspv[0][1]), .rsp_y(rspy[0])
  );

  fpalu_issue_sched #(.ALU_LAT(4), .MAX_OUT(2)) u1 (
    .clk(clk), .rst(rst),
    .req0_valid(rv[1][0]), .req0_ready(rrdy[1][0]), .req0_opcode(ropc[1][0]), .req0_opnd(ropnd[1][0]),
    .req1_valid(rv[1][1]), .req1_ready(rrdy[1][1]), .req1_opcode(ropc[1][1]), .req1_opnd(ropnd[1][1]),
    .alu_opcode(aopc[1]), .alu_a_sgn(a_as[1]), .alu_a_exp(a_ae[1]), .alu_a_man_dn(a_am[1]),
    .alu_b_sgn(a_bs[1]), .alu_b_exp(a_be[1]), .alu_b_man_dn(a_bm[1]),
    .alu_y_sgn(ypipe[1][3][28]), .alu_y_exp(ypipe[1][3][27:22]), .alu_y_man_dn(ypipe[1][3][21:0]),
    .rsp0_valid(rspv[1][0]), .rsp1_valid(rspv[1][1]), .rsp_y(rspy[1])
  );

  assign dcnt[0][0] = 3'(u0.cnt0_q);
  assign dcnt[0][1] = 3'(u0.cnt1_q);
  assign dcnt[1][0] = 3'(u1.cnt0_q);
  assign dcnt[1][1] = 3'(u1.cnt1_q);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [28:0] alu_f(input logic [1:0] opc, input logic [57:0] opnd);
    return opnd[57:29] ^ opnd[28:0] ^ {27'd0, opc};
  endfunction

  // Four-register ALU stand-in per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ypipe[i][3] <= ypipe[i][2];
      ypipe[i][2] <= ypipe[i][1];
      ypipe[i][1] <= ypipe[i][0];
      ypipe[i][0] <= alu_f(aopc[i], {a_as[i], a_ae[i], a_am[i], a_bs[i], a_be[i], a_bm[i]});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          maxo [2] = '{5, 2};
  int          m_cnt [2][2];
  bit          m_ptr [2];
  bit [1:0]    tl_v [2][8];
  logic [28:0] tl_y [2][8];
  logic [59:0] m_alu [2];
  int          cyc   = 0;
  bit          armed = 0;
  int          slot_v, g_v, nslot_v;
  bit          e0_v, e1_v;
  bit [1:0]    due_v;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0;
      m_alu[i] = '0;
      for (int k = 0; k < 2; k++) m_cnt[i][k] = 0;
      for (int s = 0; s < 8; s++) begin
        tl_v[i][s] = 2'b00;
        tl_y[i][s] = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        slot_v = cyc % 8;
        e0_v = rv[i][0] && (m_cnt[i][0] < maxo[i]);
        e1_v = rv[i][1] && (m_cnt[i][1] < maxo[i]);
        g_v = -1;
        if (!rst) begin
          if (e0_v && e1_v) g_v = int'(m_ptr[i]);
          else if (e0_v)    g_v = 0;
          else if (e1_v)    g_v = 1;
        end
        due_v = tl_v[i][slot_v];
        chk($sformatf("u%0d_ready0", i), rrdy[i][0], g_v == 0);
        chk($sformatf("u%0d_ready1", i), rrdy[i][1], g_v == 1);
        chk($sformatf("u%0d_rsp0", i), rspv[i][0], due_v[0]);
        chk($sformatf("u%0d_rsp1", i), rspv[i][1], due_v[1]);
        if (due_v != 2'b00) chk($sformatf("u%0d_rsp_y", i), rspy[i], tl_y[i][slot_v]);
        chk($sformatf("u%0d_alu_bus", i),
            {aopc[i], a_as[i], a_ae[i], a_am[i], a_bs[i], a_be[i], a_bm[i]}, m_alu[i]);
        chk($sformatf("u%0d_cnt0", i), dcnt[i][0], m_cnt[i][0]);
        chk($sformatf("u%0d_cnt1", i), dcnt[i][1], m_cnt[i][1]);
        tl_v[i][slot_v] = 2'b00;
        if (rst) begin
          m_ptr[i] = 0;
          m_alu[i] = '0;
          for (int k = 0; k < 2; k++) m_cnt[i][k] = 0;
          for (int s = 0; s < 8; s++) tl_v[i][s] = 2'b00;
        end else begin
          for (int k = 0; k < 2; k++) if (due_v[k]) m_cnt[i][k]--;
          if (g_v >= 0) begin
            m_cnt[i][g_v]++;
            m_ptr[i] = (g_v == 0);
            m_alu[i] = {ropc[i][g_v], ropnd[i][g_v]};
            nslot_v = (cyc + 5) % 8;
            tl_v[i][nslot_v] = (g_v == 0) ? 2'b01 : 2'b10;
            tl_y[i][nslot_v] = alu_f(ropc[i][g_v], ropnd[i][g_v]);
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [57:0] mk_opnd();
    seq = seq + 1;
    return {29'(seq * 32'h9E37), 29'(seq ^ 32'h15555)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) rv[i][k] = 1'b0;
  endtask

  task automatic do_reset();
    step();
    clear_reqs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic new_op(input int i, input int k);
    ropnd[i][k] = mk_opnd();
    ropc[i][k]  = 2'(seq);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) begin
        rv[i][k] = 1'b0; ropc[i][k] = '0; ropnd[i][k] = '0;
      end
    repeat (2) @(posedge clk);
    #1;
    armed = 1;

    // A: requester 0 alone on the default instance.
    do_reset();
    rv[0][0] = 1'b1;
    ropc[0][0] = 2'b01;
    ropnd[0][0] = {29'h1000_0005, 29'h0000_0003};
    @(negedge clk);
    chk("A_ready_c0", rrdy[0][0], 1);
    for (int c = 1; c < 10; c++) begin
      step();
      new_op(0, 0);
      @(negedge clk);
      if (c < 5) chk("A_ready_early", rrdy[0][0], 1);
      if (c == 5) begin
        chk("A_rsp0_c5", rspv[0][0], 1);
        chk("A_rsp_y_c5", rspy[0], 29'h1000_0007);
      end
      chk("A_rsp1_quiet", rspv[0][1], 0);
    end
    step();
    rv[0][0] = 1'b0;
    idle(10);

    // B: both requesters continuously.
    do_reset();
    rv[0][0] = 1'b1; rv[0][1] = 1'b1;
    new_op(0, 0); new_op(0, 1);
    @(negedge clk);
    chk("B_c0_ready0", rrdy[0][0], 1);
    chk("B_c0_ready1", rrdy[0][1], 0);
    for (int c = 1; c < 20; c++) begin
      step();
      new_op(0, 0); new_op(0, 1);
      @(negedge clk);
      if (c == 1) begin
        chk("B_c1_ready0", rrdy[0][0], 0);
        chk("B_c1_ready1", rrdy[0][1], 1);
      end
      if (c >= 6) begin
        chk("B_cnt0_2or3", (dcnt[0][0] == 3'd2) || (dcnt[0][0] == 3'd3), 1);
        chk("B_cnt1_2or3", (dcnt[0][1] == 3'd2) || (dcnt[0][1] == 3'd3), 1);
      end
    end
    step();
    clear_reqs();
    idle(10);

    // C: MAX_OUT=2 instance, requester 0 alone.
    do_reset();
    rv[1][0] = 1'b1;
    new_op(1, 0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        step();
        new_op(1, 0);
      end
      @(negedge clk);
      if (c <= 1) chk("C_ready_open", rrdy[1][0], 1);
      if (c >= 2 && c <= 5) chk("C_ready_stall", rrdy[1][0], 0);
      if (c == 4) chk("C_rsp0_c4", rspv[1][0], 0);
      if (c == 5) chk("C_rsp0_c5", rspv[1][0], 1);
      if (c == 6) begin
        chk("C_rsp0_c6", rspv[1][0], 1);
        chk("C_ready_c6", rrdy[1][0], 1);
      end
    end
    step();
    clear_reqs();
    idle(10);

    // D: requester 1 alone while ptr=0, then both.
    do_reset();
    rv[0][1] = 1'b1;
    new_op(0, 1);
    @(negedge clk);
    chk("D_req1_alone", rrdy[0][1], 1);
    step();
    rv[0][0] = 1'b1;
    new_op(0, 0); new_op(0, 1);
    @(negedge clk);
    chk("D_both_ready0", rrdy[0][0], 1);
    chk("D_both_ready1", rrdy[0][1], 0);
    step();
    new_op(0, 0); new_op(0, 1);
    @(negedge clk);
    chk("D_next_ready1", rrdy[0][1], 1);
    step();
    clear_reqs();
    idle(10);

    // E: reset with three operations in flight.
    do_reset();
    rv[0][0] = 1'b1;
    new_op(0, 0);
    step(); new_op(0, 0);
    step(); new_op(0, 0);
    step();
    rv[0][0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("E_cnt0_cleared", dcnt[0][0], 0);
    for (int c = 5; c < 10; c++) begin
      step();
      @(negedge clk);
      chk("E_no_rsp0", rspv[0][0], 0);
      chk("E_no_rsp1", rspv[0][1], 0);
    end
    step();
    rv[0][0] = 1'b1;
    new_op(0, 0);
    @(negedge clk);
    chk("E_new_accept", rrdy[0][0], 1);
    for (int d = 1; d <= 5; d++) begin
      step();
      rv[0][0] = 1'b0;
      @(negedge clk);
      chk("E_rsp_at_plus5", rspv[0][0], d == 5);
    end
    idle(6);

    // F: accept and response together with cnt0=3.
    do_reset();
    rv[0][0] = 1'b1;
    new_op(0, 0);
    step(); new_op(0, 0);
    step(); new_op(0, 0);
    step();
    rv[0][0] = 1'b0;
    idle(2);
    rv[0][0] = 1'b1;
    new_op(0, 0);
    @(negedge clk);
    chk("F_cnt0_before", dcnt[0][0], 3);
    chk("F_rsp0_same", rspv[0][0], 1);
    chk("F_ready0_same", rrdy[0][0], 1);
    step();
    rv[0][0] = 1'b0;
    @(negedge clk);
    chk("F_cnt0_after", dcnt[0][0], 3);
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
